// File: rtl/sparse_pkg.sv
// Shared types for the 2:4 structured-sparsity path (encoder and core loader).
package sparse_pkg;
    localparam int SPARSE_N = 2;
    localparam int SPARSE_M = 4;
    localparam int ELEM_W   = 8;

    typedef logic signed [ELEM_W-1:0] elem_t;
    typedef elem_t [SPARSE_M-1:0] dense_row_t;

    typedef struct packed {
        elem_t      val_0;
        elem_t      val_1;
        logic [1:0] idx_0;
        logic [1:0] idx_1;
    } sparse_packet_t;

    typedef enum logic [2:0] {IDLE, LOAD, WR0, WR1, DONE} enc_state_t;
endpackage

// File: rtl/sparse_24_encoder_if.sv
// Dense-row input stream plus the shared weight/index memory write port.
interface sparse_24_encoder_if import sparse_pkg::*; #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) ();
    logic              in_valid;
    logic              in_ready;
    dense_row_t        in_row;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [1:0]        mem_widx;

    modport master (output in_valid, in_row,
                    input  in_ready, mem_we, mem_addr, mem_wdata, mem_widx);
    modport slave  (input  in_valid, in_row,
                    output in_ready, mem_we, mem_addr, mem_wdata, mem_widx);
endinterface

// File: rtl/sparse_24_select.sv
// Combinational 2-of-4 picker: keeps the two largest magnitudes, ascending by index.
module sparse_24_select import sparse_pkg::*; (
    input  dense_row_t     row,
    output sparse_packet_t pkt,
    output logic           prune
);
    logic [ELEM_W:0]   mag [SPARSE_M];
    logic [2:0]        nz;
    logic [2:0]        rank;
    logic [SPARSE_M-1:0] keep;
    logic              found;

    always_comb begin
        nz    = '0;
        rank  = '0;
        keep  = '0;
        found = 1'b0;
        pkt   = '0;
        for (int i = 0; i < SPARSE_M; i++) begin
            mag[i] = row[i][ELEM_W-1] ? ((ELEM_W+1)'(0) - {1'b1, row[i]}) : {1'b0, row[i]};
            if (row[i] != '0) nz = nz + 3'd1;
        end
        // Rank each lane by magnitude, lower index winning ties; zeros rank below
        // every nonzero, so the nz<=2 padding cases fall out of the same rule.
        for (int i = 0; i < SPARSE_M; i++) begin
            rank = '0;
            for (int j = 0; j < SPARSE_M; j++)
                if (j != i && (mag[j] > mag[i] || (mag[j] == mag[i] && j < i)))
                    rank = rank + 3'd1;
            keep[i] = (rank < 3'(SPARSE_N));
        end
        for (int i = 0; i < SPARSE_M; i++) begin
            if (keep[i]) begin
                if (!found) begin
                    pkt.val_0 = row[i];
                    pkt.idx_0 = 2'(i);
                    found     = 1'b1;
                end else begin
                    pkt.val_1 = row[i];
                    pkt.idx_1 = 2'(i);
                end
            end
        end
        prune = (nz > 3'(SPARSE_N));
    end
endmodule

// File: rtl/sparse_24_encoder.sv
// Streaming 2:4 sparsity compressor writing packets to base+2r / base+2r+1.
// Optional pruned-row counter enabled by SPARSE_ENC_STATS_EN.
module sparse_24_encoder import sparse_pkg::*; #(
    parameter int NUM_ROWS = 4,
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    sparse_24_encoder_if.slave bus,
    output logic              busy,
    output logic              done,
    output logic [15:0]       pruned_cnt
);
    localparam int R_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

    enc_state_t        state, state_nxt;
    logic [R_W-1:0]    r;
    logic [ADDR_W-1:0] base_q, row_addr;
    elem_t             val_1_q;
    logic [1:0]        idx_1_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        widx_q;
    sparse_packet_t    sel_pkt;
    logic              sel_prune;
    logic              last_row, accept;

    sparse_24_select u_select (.row(bus.in_row), .pkt(sel_pkt), .prune(sel_prune));

    assign row_addr = base_q + (ADDR_W'(r) << 1);
    assign last_row = (r == R_W'(NUM_ROWS - 1));
    assign accept   = (state == LOAD) && bus.in_valid;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        bus.in_ready = 1'b0;
        busy         = (state != IDLE);
        done         = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = LOAD;
            LOAD: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_nxt = WR0;
            end
            WR0:  state_nxt = WR1;
            WR1:  state_nxt = last_row ? DONE : LOAD;
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Memory port is loaded one edge ahead so WR0/WR1 see registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r       <= '0;
            base_q  <= '0;
            val_1_q <= '0;
            idx_1_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            widx_q  <= '0;
        end else begin
            we_q <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    base_q <= base_addr;
                    r      <= '0;
                end
                LOAD: if (bus.in_valid) begin
                    val_1_q <= sel_pkt.val_1;
                    idx_1_q <= sel_pkt.idx_1;
                    we_q    <= 1'b1;
                    addr_q  <= row_addr;
                    wdata_q <= DATA_W'(sel_pkt.val_0);
                    widx_q  <= sel_pkt.idx_0;
                end
                WR0: begin
                    we_q    <= 1'b1;
                    addr_q  <= row_addr + ADDR_W'(1);
                    wdata_q <= DATA_W'(val_1_q);
                    widx_q  <= idx_1_q;
                end
                WR1: if (!last_row) r <= r + R_W'(1);
                default: ;
            endcase
        end
    end

    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_widx  = widx_q;

`ifdef SPARSE_ENC_STATS_EN
    logic [15:0] cnt_q;
    always_ff @(posedge clk) begin
        if (rst)                                        cnt_q <= '0;
        else if (state == IDLE && start)                cnt_q <= '0;
        else if (accept && sel_prune && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end
    assign pruned_cnt = cnt_q;
`else
    logic unused_stats;
    assign unused_stats = sel_prune & accept;
    assign pruned_cnt   = '0;
`endif
endmodule

// File: tb/tb_sparse_24_encoder.sv
// Scoreboard bench: expected writes queued at row acceptance, compared as mem_we fires.
module tb_sparse_24_encoder;
    import sparse_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [9:0]  base_addr;
    logic        busy, done;
    logic [15:0] pruned_cnt;

    sparse_24_encoder_if #(.ADDR_W(10), .DATA_W(8)) bus ();

    sparse_24_encoder #(.NUM_ROWS(4), .ADDR_W(10), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .bus(bus), .busy(busy), .done(done), .pruned_cnt(pruned_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] addr;
        logic [7:0] data;
        logic [1:0] idx;
    } wr_t;

    wr_t        sb[$];
    wr_t        mon_e;
    int         checks = 0, errors = 0;
    int         cyc = 0, last_we_cyc = 0, done_cnt = 0;
    logic [9:0] cur_base;
    int         cur_r, exp_pruned;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            last_we_cyc = cyc;
            if (sb.size() == 0) chk("unexpected_we", 1, 0);
            else begin
                mon_e = sb.pop_front();
                chk("mem_write", {bus.mem_addr, bus.mem_wdata, bus.mem_widx}, mon_e);
            end
        end
        if (done === 1'b1) begin
            done_cnt++;
            chk("done_gap", cyc - last_we_cyc, 1);
            chk("done_busy", busy, 1);
        end
    end

    function automatic dense_row_t mk(input int a0, a1, a2, a3);
        dense_row_t t;
        t[0] = 8'(a0); t[1] = 8'(a1); t[2] = 8'(a2); t[3] = 8'(a3);
        return t;
    endfunction

    function automatic logic [7:0] rnd_elem();
        case ($urandom_range(0, 3))
            0:       return 8'h00;
            1:       return 8'h80;
            default: return 8'($urandom);
        endcase
    endfunction

    function automatic dense_row_t rnd_row();
        dense_row_t t;
        for (int k = 0; k < 4; k++) t[k] = rnd_elem();
        return t;
    endfunction

    // Reference: nonzeros then zero pads for sparse rows, two arg-max passes otherwise.
    function automatic void model(input dense_row_t row, output logic [7:0] v0, v1,
                                  output logic [1:0] i0, i1, output bit pr);
        int a[4];
        int lst[4];
        int n, nzc, m1, m2, t;
        nzc = 0; n = 0;
        for (int k = 0; k < 4; k++) begin
            a[k] = (row[k] < 0) ? -int'(row[k]) : int'(row[k]);
            if (row[k] != 0) nzc++;
        end
        pr = (nzc > 2);
        if (nzc <= 2) begin
            for (int k = 0; k < 4; k++) if (row[k] != 0) begin lst[n] = k; n++; end
            for (int k = 0; k < 4; k++) if (row[k] == 0) begin lst[n] = k; n++; end
            m1 = lst[0]; m2 = lst[1];
        end else begin
            m1 = 0;
            for (int k = 1; k < 4; k++) if (a[k] > a[m1]) m1 = k;
            m2 = (m1 == 0) ? 1 : 0;
            for (int k = 0; k < 4; k++) if (k != m1 && a[k] > a[m2]) m2 = k;
        end
        if (m2 < m1) begin t = m1; m1 = m2; m2 = t; end
        v0 = row[m1]; v1 = row[m2]; i0 = 2'(m1); i1 = 2'(m2);
    endfunction

    task automatic start_matrix(input logic [9:0] b);
        start = 1'b1; base_addr = b;
        cur_base = b; cur_r = 0; exp_pruned = 0;
        @(negedge clk);
        start = 1'b0; base_addr = 10'h155;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic send_row(input dense_row_t row, input bit poke_start);
        logic [7:0] v0, v1;
        logic [1:0] i0, i1;
        logic [9:0] a;
        bit pr, ok;
        model(row, v0, v1, i0, i1, pr);
        bus.in_valid = 1'b1; bus.in_row = row; ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            if (bus.in_ready === 1'b1) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) chk("accept_timeout", 0, 1);
        else begin
            a = cur_base + 10'(cur_r * 2);
            sb.push_back({a, v0, i0});
            sb.push_back({a + 10'd1, v1, i1});
            exp_pruned += int'(pr);
            cur_r++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        if (poke_start) begin
            start = 1'b1; base_addr = 10'h2AA;
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic wait_done();
        int d0;
        d0 = done_cnt;
        for (int k = 0; k < 100 && done_cnt == d0; k++) @(negedge clk);
        if (done_cnt == d0) chk("done_timeout", 0, 1);
        @(negedge clk);
        chk("busy_idle", busy, 0);
        chk("done_low", done, 0);
        chk("sb_drained", sb.size(), 0);
`ifdef SPARSE_ENC_STATS_EN
        chk("pruned_cnt", pruned_cnt, 32'(exp_pruned));
`else
        chk("pruned_cnt", pruned_cnt, 0);
`endif
    endtask

    initial begin
        bit hit;
        rst = 1'b1; start = 1'b0; base_addr = '0;
        bus.in_valid = 1'b0; bus.in_row = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_mem_widx", bus.mem_widx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pruned", pruned_cnt, 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed rows at base 0, with an idle stretch in LOAD and a stray start in WR0.
        start_matrix(10'h000);
        for (int k = 0; k < 5; k++) begin
            chk("hold_in_ready", bus.in_ready, 1);
            chk("hold_no_we", bus.mem_we, 0);
            @(negedge clk);
        end
        send_row(mk(7, 0, 0, 14), 1'b0);
        send_row(mk(3, -9, 5, 9), 1'b1);
        send_row(mk(0, 0, 0, 0), 1'b0);
        send_row(mk(5, -5, 5, 0), 1'b0);
        wait_done();

        // Wrapping base, random rows.
        start_matrix(10'h3FE);
        for (int k = 0; k < 4; k++) send_row(rnd_row(), 1'b0);
        wait_done();

        // Reset during WR1 of row 1 aborts the matrix.
        start_matrix(10'h040);
        send_row(mk(-128, 127, -128, 1), 1'b0);
        send_row(rnd_row(), 1'b0);
        hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin
            if (bus.mem_we === 1'b1 && bus.mem_addr === 10'h043) hit = 1'b1;
            else @(negedge clk);
        end
        if (!hit) chk("wr1_timeout", 0, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_we", bus.mem_we, 0);
        chk("abort_in_ready", bus.in_ready, 0);
        chk("abort_pruned", pruned_cnt, 0);
        sb.delete();
        @(negedge clk);

        // Fresh matrix after the abort.
        start_matrix(10'h100);
        for (int k = 0; k < 4; k++) send_row(rnd_row(), 1'b0);
        wait_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got 0 expected 1");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/sparse_24_encoder.md
Name: sparse_24_encoder

Overview:
Streaming 2:4 structured-sparsity compressor; the write-side counterpart of the weight loader that feeds sparse_core.
- Accepts dense int8 weight rows, 4 values each, over a valid/ready handshake.
- Reduces each row to a packet of two nonzero values plus 2-bit indices.
- Writes the packet into the flat weight/index memories at addresses 2*r and 2*r+1, the layout the core loader reads.
- Runs once per matrix, triggered by start; signals done.

Parameters:
NUM_ROWS, 4, rows per matrix (PE count)
ADDR_W, 10, memory address width (1024-entry memories)
DATA_W, 8, weight width (signed)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start  in  1  begin matrix; honoured only in IDLE
base_addr  in  ADDR_W  first memory address; latched on start
in_valid  in  1  dense row valid
in_ready  out  1  encoder can take a row
in_row  in  4xDATA_W  dense row, element k = column k, signed
mem_we  out  1  write strobe for both memories
mem_addr  out  ADDR_W  write address
mem_wdata  out  DATA_W  value written to weight memory
mem_widx  out  2  index written to index memory
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse after the last write
pruned_cnt  out  16  rows that needed pruning (see Optional Feature)

Behaviour:
- Reset (rst sampled high at posedge):
  - state=IDLE; row counter r=0.
  - All outputs 0: in_ready, mem_we, mem_addr, mem_wdata, mem_widx, busy, done, pruned_cnt.
  - Reset mid-operation aborts the matrix; no write occurs in the reset cycle.
- FSM states: IDLE, LOAD, WR0, WR1, DONE.
  - IDLE: start=1 latches base_addr, sets r=0, goes to LOAD. in_ready=0. start in any other state is ignored.
  - LOAD: in_ready=1. When in_valid&in_ready, register the selected packet and go to WR0. in_valid low holds LOAD indefinitely.
  - WR0: mem_we=1, mem_addr=base+2r, mem_wdata=val_0, mem_widx=idx_0. Then go to WR1.
  - WR1: mem_we=1, mem_addr=base+2r+1, mem_wdata=val_1, mem_widx=idx_1. If r==NUM_ROWS-1 go to DONE, else r++ and go to LOAD.
  - DONE: done=1 for one cycle, then IDLE.
- Throughput and latency:
  - 3 cycles per row minimum.
  - Row accepted at edge t → WR0 outputs during cycle t+1, WR1 during cycle t+2.
- Address arithmetic is modulo 2^ADDR_W; wrap is silent.
- mem_* outputs are registered. mem_we=0 outside WR0/WR1; mem_addr/wdata/widx then hold their last values.
- Selection (combinational on in_row; result registered at acceptance). nz = count of nonzero elements.
  - nz=0: val_0=val_1=0, idx_0=0, idx_1=1.
  - nz=1: nonzero element plus a zero pad at the lowest unused index; the pair is ordered ascending by index.
  - nz=2: both nonzeros, ascending index.
  - nz>2: keep the two largest |v|. |-128|=128, computed at DATA_W+1 bits. Tie goes to the lower index. Output is ascending by index.
  - Invariant: idx_0 < idx_1 always.

Optional Feature:
Macro SPARSE_ENC_STATS_EN.
- Defined: pruned_cnt increments by 1 per accepted row with nz>2 and saturates at 0xFFFF. It clears on rst and on an accepted start.
- Undefined: pruned_cnt tied to 0; no counter logic is synthesised.

Decomposition:
- sparse_pkg gains:
  - dense_row_t (4 x logic signed [7:0])
  - constant SPARSE_N=2, SPARSE_M=4
  - enc_state_t enum
- Existing sparse_packet_t (val_0, val_1, idx_0, idx_1) is reused as the registered packet.
- One sub-module: sparse_24_select, purely combinational, dense_row_t → sparse_packet_t plus a prune flag; unit-testable alone.

Test Plan:
- base=0, row [7,0,0,14] → WR0 addr 0x000 data 0x07 idx 00; WR1 addr 0x001 data 0x0E idx 11; pruned_cnt stays 0.
- Row [3,-9,5,9] → data 0xF7 idx 01, then 0x09 idx 11. With SPARSE_ENC_STATS_EN, pruned_cnt=1; without it, 0.
- Row [0,0,0,0] → data 0x00/0x00, idx 00/01. Tie row [5,-5,5,0] → 0x05 idx 00, 0xFB idx 01.
- Full 4-row matrix with base 0x3FE → write addresses 0x3FE, 0x3FF, 0x000, …, 0x005. done pulses exactly one cycle after the final WR1; busy falls with it.
- in_valid held low 5 cycles in LOAD → in_ready stays 1, no mem_we. start pulsed during WR0 → ignored, sequence unchanged.
- rst asserted during WR1 of row 1 → next cycle state IDLE, mem_we=0, busy=0. A fresh start then rewrites from base.
